led_pattern_sequencer: RTL and testbench

LED_PATTERN_SEQUENCER -- requirements
Module: led_pattern_sequencer

---
 rtl/led_seq_pkg.sv | 20 ++
 rtl/led_pattern_sequencer_if.sv | 36 +++
 rtl/led_pattern_sequencer_tick_gen.sv | 33 +++
 rtl/led_pattern_sequencer.sv | 160 ++++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared constants for the LED pattern sequencer.
//   - parameter defaults (LED width, pattern depth, tick counter width)
//   - playback mode encoding
//   - sequencer state encoding
package led_seq_pkg;

  localparam int LED_W_DEF  = 8;
  localparam int DEPTH_DEF  = 8;
  localparam int TICK_W_DEF = 28;

  localparam logic [1:0] MODE_ONESHOT  = 2'b00;
  localparam logic [1:0] MODE_LOOP     = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;
  localparam logic [1:0] MODE_HOLD     = 2'b11;

  localparam logic [1:0] ST_IDLE     = 2'b00;
  localparam logic [1:0] ST_RUN      = 2'b01;
  localparam logic [1:0] ST_HOLDLAST = 2'b10;

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// led_pattern_sequencer_if: control, pattern-write and status signals of the
// LED pattern sequencer.
//   master: drives start/stop/mode/seq_len/step_ticks and the write port,
//           observes led/busy/done/idx
//   slave : the sequencer side
interface led_pattern_sequencer_if #(
  parameter int LED_W  = 8,
  parameter int DEPTH  = 8,
  parameter int TICK_W = 28
) ();
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic              start;
  logic              stop;
  logic [1:0]        mode;
  logic [LW-1:0]     seq_len;
  logic [TICK_W-1:0] step_ticks;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [LED_W-1:0]  wr_data;
  logic [LED_W-1:0]  led;
  logic              busy;
  logic              done;
  logic [AW-1:0]     idx;

  modport master (
    output start, stop, mode, seq_len, step_ticks, wr_en, wr_addr, wr_data,
    input  led, busy, done, idx
  );

  modport slave (
    input  start, stop, mode, seq_len, step_ticks, wr_en, wr_addr, wr_data,
    output led, busy, done, idx
  );
endinterface

// File: rtl/led_pattern_sequencer_tick_gen.sv
// tick_gen: step-duration timer.
//   clk, rst_n : clock, async active-low reset
//   load       : restart the count at 1 (first clock of a new step)
//   en         : count while a sequence is running
//   period     : clocks per step; 0 behaves as 1
//   tick       : high on the last clock of the current step
// The counter runs 1..max(period,1) and wraps, so it can never overflow.
module tick_gen #(
  parameter int TICK_W = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              en,
  input  logic [TICK_W-1:0] period,
  output logic              tick
);
  logic [TICK_W-1:0] cnt_q;
  logic [TICK_W-1:0] period_eff;

  assign period_eff = (period == '0) ? TICK_W'(1) : period;
  assign tick       = en && (cnt_q == period_eff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= TICK_W'(1);
    end else if (en) begin
      cnt_q <= tick ? TICK_W'(1) : cnt_q + TICK_W'(1);
    end
  end
endmodule

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: plays a table of LED patterns, one entry per step.
//   clk, rst_n : clock, async active-low reset
//   bus.slave  : start/stop/mode/seq_len/step_ticks control, pattern write
//                port (wr_en/wr_addr/wr_data), led/busy/done/idx status
//
// state       | meaning
// ST_IDLE     | no sequence; led=0
// ST_RUN      | stepping through entries; led follows mem[idx]
// ST_HOLDLAST | HOLD mode finished; led follows mem[L-1]
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int LED_W  = LED_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int TICK_W = TICK_W_DEF
) (
  input logic                    clk,
  input logic                    rst_n,
  led_pattern_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [1:0]        state_q;
  logic [1:0]        mode_q;
  logic [LW-1:0]     len_q;
  logic [TICK_W-1:0] ticks_q;
  logic [AW-1:0]     idx_q, idx_nxt, last_idx;
  logic              dir_q, dir_nxt;     // pingpong: 0 = counting up
  logic [LED_W-1:0]  led_q;
  logic              busy_q, done_q;
  logic [LED_W-1:0]  mem_q [DEPTH];
  logic              tick;
  logic              start_ok;
  logic [LW-1:0]     len_in;
  logic              seq_end;

  assign start_ok = bus.start && !bus.stop && (state_q != ST_RUN);
  assign len_in   = (bus.seq_len > DEPTH_L) ? DEPTH_L : bus.seq_len;
  assign last_idx = AW'(len_q - LW'(1));
  assign seq_end  = tick && (idx_q == last_idx) &&
                    ((mode_q == MODE_ONESHOT) || (mode_q == MODE_HOLD));

  assign bus.led  = led_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.idx  = idx_q;

  tick_gen #(.TICK_W(TICK_W)) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (start_ok),
    .en     (state_q == ST_RUN),
    .period (ticks_q),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (bus.wr_en) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_comb begin
    idx_nxt = idx_q;
    dir_nxt = dir_q;
    if (tick) begin
      case (mode_q)
        MODE_LOOP: idx_nxt = (idx_q == last_idx) ? '0 : idx_q + AW'(1);
        MODE_PINGPONG: begin
          if (last_idx == '0) begin
            idx_nxt = '0;
          end else if (!dir_q) begin
            if (idx_q == last_idx) begin
              idx_nxt = idx_q - AW'(1);
              dir_nxt = 1'b1;
            end else begin
              idx_nxt = idx_q + AW'(1);
            end
          end else begin
            if (idx_q == '0) begin
              idx_nxt = AW'(1);
              dir_nxt = 1'b0;
            end else begin
              idx_nxt = idx_q - AW'(1);
            end
          end
        end
        default:   idx_nxt = idx_q + AW'(1);
      endcase
    end
  end

  // led is loaded from mem[idx_nxt] so it lines up with idx; a write to the
  // displayed entry shows one cycle after its write edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      len_q   <= '0;
      ticks_q <= '0;
      idx_q   <= '0;
      dir_q   <= 1'b0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.stop) begin
        state_q <= ST_IDLE;
        idx_q   <= '0;
        dir_q   <= 1'b0;
        led_q   <= '0;
        busy_q  <= 1'b0;
      end else if (start_ok) begin
        mode_q  <= bus.mode;
        len_q   <= len_in;
        ticks_q <= bus.step_ticks;
        idx_q   <= '0;
        dir_q   <= 1'b0;
        if (len_in == '0) begin
          state_q <= ST_IDLE;
          led_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          state_q <= ST_RUN;
          led_q   <= mem_q[0];
          busy_q  <= 1'b1;
        end
      end else begin
        case (state_q)
          ST_RUN: begin
            if (seq_end) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              if (mode_q == MODE_HOLD) begin
                state_q <= ST_HOLDLAST;
                led_q   <= mem_q[last_idx];
              end else begin
                state_q <= ST_IDLE;
                idx_q   <= '0;
                led_q   <= '0;
              end
            end else begin
              idx_q <= idx_nxt;
              dir_q <= dir_nxt;
              led_q <= mem_q[idx_nxt];
            end
          end
          ST_HOLDLAST: led_q <= mem_q[last_idx];
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_led_pattern_sequencer.sv
module tb_led_pattern_sequencer;
  localparam int LED_W  = 8;
  localparam int DEPTH  = 8;
  localparam int TICK_W = 28;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   mem_model [DEPTH];

  led_pattern_sequencer_if #(.LED_W(LED_W), .DEPTH(DEPTH), .TICK_W(TICK_W)) bus ();

  led_pattern_sequencer #(.LED_W(LED_W), .DEPTH(DEPTH), .TICK_W(TICK_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mode;
    int len;
    int ticks;
    int cycles;
    int restart_at;
    int exp_busy;
    int exp_done;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs k cycles after the accepting edge, derived from the
  // playback rules: step s = k / T, entry chosen by mode arithmetic.
  function automatic void model(input int mode, input int len, input int ticks, input int k,
                                output int e_led, output int e_idx, output int e_busy,
                                output int e_done);
    int l, t, s, p, per;
    l = (len > DEPTH) ? DEPTH : len;
    t = (ticks == 0) ? 1 : ticks;
    e_led = 0; e_idx = 0; e_busy = 0; e_done = 0;
    if (l == 0) begin
      e_done = (k == 0) ? 1 : 0;
      return;
    end
    s = k / t;
    if (mode == 0 || mode == 3) begin
      if (s < l) begin
        e_busy = 1; e_idx = s; e_led = mem_model[s];
      end else begin
        e_done = (k == l * t) ? 1 : 0;
        if (mode == 3) begin
          e_idx = l - 1; e_led = mem_model[l - 1];
        end
      end
    end else begin
      e_busy = 1;
      if (mode == 1) e_idx = s % l;
      else if (l == 1) e_idx = 0;
      else begin
        per = 2 * l - 2;
        p = s % per;
        e_idx = (p < l) ? p : per - p;
      end
      e_led = mem_model[e_idx];
    end
  endfunction

  task automatic wr(input int addr, input int data);
    @(posedge clk); #1;
    bus.wr_en = 1'b1; bus.wr_addr = 3'(addr); bus.wr_data = 8'(data);
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    mem_model[addr] = data;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_led"},  int'(bus.led),  0);
    chk({tag, "_idx"},  int'(bus.idx),  0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
  endtask

  task automatic run_seq(input int mode, input int len, input int ticks, input int n,
                         input int restart_at, input bit do_stop,
                         output int busy_cnt, output int done_cnt);
    int el, ei, eb, ed;
    busy_cnt = 0; done_cnt = 0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.mode = 2'(mode); bus.seq_len = 4'(len); bus.step_ticks = 28'(ticks);
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 0; k < n; k++) begin
      model(mode, len, ticks, k, el, ei, eb, ed);
      chk("seq_led",  int'(bus.led),  el);
      chk("seq_idx",  int'(bus.idx),  ei);
      chk("seq_busy", int'(bus.busy), eb);
      chk("seq_done", int'(bus.done), ed);
      busy_cnt += int'(bus.busy);
      done_cnt += int'(bus.done);
      if (k == restart_at) begin
        bus.start = 1'b1; bus.mode = 2'b00; bus.seq_len = '0; bus.step_ticks = '0;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    if (do_stop) begin
      bus.stop = 1'b1;
      @(posedge clk); #1;
      bus.stop = 1'b0;
      check_idle("after_stop");
    end
  endtask

  vec_t vecs [8];
  int   bc, dc;

  initial begin
    bus.start = 0; bus.stop = 0; bus.mode = 0; bus.seq_len = 0; bus.step_ticks = 0;
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
    for (int i = 0; i < DEPTH; i++) mem_model[i] = 0;

    vecs[0] = '{0, 4, 3, 40, -1, 12, 1};
    vecs[1] = '{0, 9, 1, 40, -1, 8, 1};
    vecs[2] = '{3, 2, 0, 40, -1, 2, 1};
    vecs[3] = '{0, 0, 5, 40, -1, 0, 1};
    vecs[4] = '{3, 3, 2, 40, -1, 6, 1};
    vecs[5] = '{1, 3, 1, 40, 5, 40, 0};
    vecs[6] = '{2, 1, 1, 40, -1, 40, 0};
    vecs[7] = '{2, 4, 2, 40, -1, 40, 0};

    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) wr(i, 1 << i);

    foreach (vecs[i]) begin
      run_seq(vecs[i].mode, vecs[i].len, vecs[i].ticks, vecs[i].cycles,
              vecs[i].restart_at, 1'b1, bc, dc);
      chk($sformatf("vec%0d_busy_cycles", i), bc, vecs[i].exp_busy);
      chk($sformatf("vec%0d_done_pulses", i), dc, vecs[i].exp_done);
    end

    // HOLD: last entry tracks writes one cycle after the write edge
    wr(0, 'h11);
    wr(1, 'hAA);
    run_seq(3, 2, 1, 4, -1, 1'b0, bc, dc);
    chk("hold_led", int'(bus.led), 'hAA);
    bus.wr_en = 1'b1; bus.wr_addr = 3'd1; bus.wr_data = 8'h55;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    chk("hold_led_write_edge", int'(bus.led), 'hAA);
    mem_model[1] = 'h55;
    @(posedge clk); #1;
    chk("hold_led_after_write", int'(bus.led), 'h55);
    chk("hold_busy", int'(bus.busy), 0);
    bus.stop = 1'b1;
    @(posedge clk); #1;
    bus.stop = 1'b0;
    check_idle("hold_stop");

    // stop during the third step of a 4-entry oneshot
    run_seq(0, 4, 2, 5, -1, 1'b1, bc, dc);
    chk("stop_no_done", dc, 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check_idle("stop_stays_idle");
    end

    // start and stop together
    @(posedge clk); #1;
    bus.start = 1'b1; bus.stop = 1'b1; bus.mode = 2'b01; bus.seq_len = 4'd3; bus.step_ticks = 28'd1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.stop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_idle("start_stop");
      @(posedge clk); #1;
    end

    // randomized runs against the model
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < DEPTH; i++) wr(i, int'($urandom_range(255)));
      run_seq(int'($urandom_range(3)), int'($urandom_range(9)), int'($urandom_range(3)),
              30, -1, 1'b1, bc, dc);
    end

    // async reset mid-run, then first start right at release
    run_seq(1, 3, 1, 4, -1, 1'b0, bc, dc);
    rst_n = 1'b0;
    #2;
    check_idle("async_rst");
    @(posedge clk); #1;
    check_idle("rst_held");
    for (int i = 0; i < DEPTH; i++) mem_model[i] = 0;
    rst_n = 1'b1;
    bus.start = 1'b1; bus.mode = 2'b00; bus.seq_len = 4'd3; bus.step_ticks = 28'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("first_start_busy", int'(bus.busy), 1);
    chk("mem_cleared_led", int'(bus.led), 0);
    bus.stop = 1'b1;
    @(posedge clk); #1;
    bus.stop = 1'b0;
    check_idle("final_stop");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
